// File: rtl/xcprt_uart_pkg.sv
// rtl/xcprt_uart_pkg.sv - shared register map, status layout and FSM states for xcprt_uart
package xcprt_uart_pkg;

  localparam logic [1:0] CPRT_TXDATA = 2'd0;
  localparam logic [1:0] CPRT_STATUS = 2'd1;
  localparam logic [1:0] CPRT_DIV    = 2'd2;

  localparam int STAT_BUSY  = 0;
  localparam int STAT_EMPTY = 1;
  localparam int STAT_FULL  = 2;
  localparam int STAT_OVF   = 3;
  localparam int STAT_COUNT = 8;

  localparam int DIV_RST_DEFAULT = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_t;

endpackage

// File: rtl/xcprt_fifo.sv
// rtl/xcprt_fifo.sv - synchronous FIFO; a push into a full FIFO is accepted only alongside a pop
module xcprt_fifo #(
  parameter int DEPTH = 8,
  parameter int AW    = 3,
  parameter int W     = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  logic [W-1:0]  i_din,
  input  logic          i_pop,
  output logic [W-1:0]  o_dout,
  output logic          o_full,
  output logic          o_empty,
  output logic [AW:0]   o_count
);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_dout    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/xcprt_uart.sv
// rtl/xcprt_uart.sv - select-addressed character output port: TX FIFO feeding an 8N1 UART
module xcprt_uart
  import xcprt_uart_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 2,
  parameter int FIFO_DEPTH = 8,
  parameter int FIFO_AW    = 3,
  parameter int DIV_W      = 16,
  parameter int DIV_RST    = DIV_RST_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sel,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              txd,
  output logic              irq_empty
);

  tx_state_t        r_state;
  logic             r_txd;
  logic [7:0]       r_shift;
  logic [2:0]       r_bit_cnt;
  logic [DIV_W-1:0] r_clk_cnt;
  logic [DIV_W-1:0] r_period;
  logic [DIV_W-1:0] r_div;
  logic             r_ovf;

  logic             w_wr;
  logic             w_rd;
  logic             w_push_req;
  logic             w_pop;
  logic             w_bit_end;
  logic [DIV_W-1:0] w_period_next;
  logic [7:0]       w_head;
  logic             w_full;
  logic             w_empty;
  logic [FIFO_AW:0] w_count;
  logic             w_unused;

  assign w_wr          = sel & we;
  assign w_rd          = sel & ~we;
  assign w_push_req    = w_wr && (addr == ADDR_W'(CPRT_TXDATA));
  assign w_bit_end     = (r_clk_cnt == r_period - DIV_W'(1));
  assign w_period_next = (r_div == '0) ? DIV_W'(1) : r_div;
  assign w_unused      = ^data_in[DATA_W-1:DIV_W];

  // The load decision is combinational so the pop lands on the same edge the FSM captures the head.
  assign w_pop = ~w_empty & ((r_state == ST_IDLE) | ((r_state == ST_STOP) & w_bit_end));

  xcprt_fifo #(.DEPTH(FIFO_DEPTH), .AW(FIFO_AW), .W(8)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push_req),
    .i_din   (data_in[7:0]),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_txd     <= 1'b1;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_clk_cnt <= '0;
      r_period  <= DIV_W'(1);
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            r_shift   <= w_head;
            r_period  <= w_period_next;
            r_clk_cnt <= '0;
            r_txd     <= 1'b0;
            r_state   <= ST_START;
          end
        end
        ST_START: begin
          if (w_bit_end) begin
            r_clk_cnt <= '0;
            r_bit_cnt <= '0;
            r_txd     <= r_shift[0];
            r_state   <= ST_DATA;
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (w_bit_end) begin
            r_clk_cnt <= '0;
            r_shift   <= r_shift >> 1;
            if (r_bit_cnt == 3'd7) begin
              r_txd   <= 1'b1;
              r_state <= ST_STOP;
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
              r_txd     <= r_shift[1];
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        ST_STOP: begin
          if (w_bit_end) begin
            r_clk_cnt <= '0;
            if (w_pop) begin
              r_shift  <= w_head;
              r_period <= w_period_next;
              r_txd    <= 1'b0;
              r_state  <= ST_START;
            end else begin
              r_state <= ST_IDLE;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div <= DIV_W'(DIV_RST);
      r_ovf <= 1'b0;
    end else if (w_wr) begin
      case (addr)
        ADDR_W'(CPRT_TXDATA): if (w_full && !w_pop) r_ovf <= 1'b1;
        ADDR_W'(CPRT_STATUS): r_ovf <= 1'b0;
        ADDR_W'(CPRT_DIV):    r_div <= data_in[DIV_W-1:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    data_out = '0;
    if (w_rd) begin
      case (addr)
        ADDR_W'(CPRT_STATUS): begin
          data_out[STAT_BUSY]                 = (r_state != ST_IDLE);
          data_out[STAT_EMPTY]                = w_empty;
          data_out[STAT_FULL]                 = w_full;
          data_out[STAT_OVF]                  = r_ovf;
          data_out[STAT_COUNT +: FIFO_AW + 1] = w_count;
        end
        ADDR_W'(CPRT_DIV): data_out = DATA_W'(r_div);
        default: data_out = '0;
      endcase
    end
  end

  assign txd       = r_txd;
  assign irq_empty = w_empty & (r_state == ST_IDLE);

endmodule

// File: tb/tb_xcprt_uart.sv
// tb/tb_xcprt_uart.sv - scoreboard bench: driver queues expected frames, a line monitor decodes txd
module tb_xcprt_uart;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sel = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  addr = 2'd0;
  logic [31:0] data_in = 32'd0;
  logic [31:0] data_out;
  logic        txd;
  logic        irq_empty;

  xcprt_uart dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sel       (sel),
    .we        (we),
    .addr      (addr),
    .data_in   (data_in),
    .data_out  (data_out),
    .txd       (txd),
    .irq_empty (irq_empty)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] b;
    int         p;
    int         start;
  } frame_t;

  frame_t exp_q[$];
  int     n_cmp = 0;
  int     n_bad = 0;
  int     last_wr = 0;
  int     last_start = 0;
  bit     mon_active = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    sel = 1'b1; we = 1'b1; addr = a; data_in = d;
    @(posedge clk);
    last_wr = cyc;
    #1;
    sel = 1'b0; we = 1'b0; data_in = 32'd0;
  endtask

  task automatic rd_check(input string name, input logic [1:0] a, input logic [31:0] exp);
    @(negedge clk);
    sel = 1'b1; we = 1'b0; addr = a;
    #1;
    check(name, data_out, exp);
    sel = 1'b0;
  endtask

  // start < 0: line was idle, so the start bit is first sampled two negedges after the write edge
  task automatic tx(input logic [7:0] b, input int p, input int start);
    frame_t f;
    wr(2'd0, {24'd0, b});
    f.b = b;
    f.p = p;
    f.start = (start < 0) ? last_wr + 2 : start;
    last_start = f.start;
    exp_q.push_back(f);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (irq_empty && !mon_active && exp_q.size() == 0) break;
    end
    check(name, 32'(i < budget), 32'd1);
  endtask

  initial begin
    frame_t cur;
    int     slot;
    int     sub;
    bit     bad;
    bit     junk;
    logic   obs;
    logic   expb;
    slot = 0; sub = 0; bad = 0; junk = 0; obs = 1'b1; expb = 1'b1;
    cur.b = 8'd0; cur.p = 1; cur.start = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mon_active = 1'b0;
        junk = 1'b0;
      end else begin
        if (junk && txd) junk = 1'b0;
        if (!mon_active && !junk && txd == 1'b0) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            junk = 1'b1;
            $display("FAIL unexpected_frame: got start bit at cycle %0d, expected idle line", cyc);
          end else begin
            cur = exp_q.pop_front();
            mon_active = 1'b1;
            slot = 0; sub = 0; bad = 0;
            check($sformatf("start_cycle_byte%02h", cur.b), 32'(cyc), 32'(cur.start));
          end
        end
        if (mon_active) begin
          expb = (slot == 0) ? 1'b0 : (slot == 9) ? 1'b1 : cur.b[slot-1];
          if (txd !== expb) begin
            bad = 1'b1;
            obs = txd;
          end
          sub++;
          if (sub == cur.p) begin
            check($sformatf("byte%02h_slot%0d", cur.b, slot), {31'd0, bad ? obs : expb}, {31'd0, expb});
            slot++; sub = 0; bad = 0;
            if (slot == 10) mon_active = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    int s;
    #23;
    check("rst_txd", {31'd0, txd}, 32'd1);
    check("rst_irq_empty", {31'd0, irq_empty}, 32'd1);
    check("rst_data_out_idle", data_out, 32'd0);
    rd_check("rst_status", 2'd1, 32'h0000_0002);
    rd_check("rst_div", 2'd2, 32'd16);
    rd_check("rst_txdata_rd", 2'd0, 32'd0);
    rd_check("rst_reserved_rd", 2'd3, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // single 0x55 frame at P=4
    wr(2'd2, 32'd4);
    rd_check("div4_rd", 2'd2, 32'd4);
    tx(8'h55, 4, -1);
    rd_check("status_pending", 2'd1, 32'h0000_0100);
    repeat (40) @(posedge clk);
    #1;
    check("busy_at_40", {31'd0, irq_empty}, 32'd0);
    @(posedge clk);
    #1;
    check("idle_after_frame", {31'd0, irq_empty}, 32'd1);
    check("txd_idle_after_frame", {31'd0, txd}, 32'd1);
    wait_idle("idle_t2", 50);

    // back-to-back frames at P=2
    wr(2'd2, 32'd2);
    tx(8'h41, 2, -1);
    s = last_start;
    tx(8'h42, 2, s + 20);
    wait_idle("idle_t3", 100);

    // fill, overflow and clear at P=100
    wr(2'd2, 32'd100);
    tx(8'h10, 100, -1);
    s = last_start;
    for (int i = 1; i < 9; i++) tx(8'h10 + 8'(i), 100, s + i * 1000);
    rd_check("status_full", 2'd1, 32'h0000_0805);
    wr(2'd0, 32'h0000_00EE);
    rd_check("status_ovf", 2'd1, 32'h0000_080D);
    wr(2'd1, 32'd0);
    rd_check("status_ovf_clr", 2'd1, 32'h0000_0805);
    wait_idle("idle_t4", 9500);

    // divisor 0 behaves as 1; mid-frame divisor write applies to next frame only
    wr(2'd2, 32'd0);
    rd_check("div0_rd", 2'd2, 32'd0);
    tx(8'h3C, 1, -1);
    s = last_start;
    tx(8'hC3, 8, s + 10);
    wr(2'd2, 32'd8);
    wait_idle("idle_t5", 200);

    // asynchronous reset in the middle of the data bits
    wr(2'd2, 32'd4);
    tx(8'hA5, 4, -1);
    repeat (10) @(negedge clk);
    check("txd_before_rst", {31'd0, txd}, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("txd_async_rst", {31'd0, txd}, 32'd1);
    check("irq_async_rst", {31'd0, irq_empty}, 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    rd_check("status_after_rst", 2'd1, 32'h0000_0002);
    check("txd_quiet_after_rst", {31'd0, txd}, 32'd1);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/xcprt_uart.md
Name: xcprt_uart

Overview:
Memory-mapped character-output peripheral that responds to the controller's `cprt_sel` select from the data address decoder. Controller writes bytes into an 8-entry TX FIFO; a UART transmitter drains the FIFO onto a serial line (8N1, LSB first). Status and divisor registers are readable through the same select-addressed read path, so the decoder can mux `data_out` into `data_to_rd`.

Parameters:
DATA_W, 32, controller data bus width
ADDR_W, 2, local register offset width (low address bits below the select field)
FIFO_DEPTH, 8, TX FIFO entries; must be a power of 2
FIFO_AW, 3, log2(FIFO_DEPTH)
DIV_W, 16, baud divisor width
DIV_RST, 16, divisor reset value (clocks per bit)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
sel  in  1  peripheral select from address decoder (`cprt_sel`)
we  in  1  write enable, qualified by sel
addr  in  ADDR_W  register offset: 0 TXDATA, 1 STATUS, 2 DIV, 3 reserved
data_in  in  DATA_W  write data
data_out  out  DATA_W  read data, combinational
txd  out  1  serial output, idle high
irq_empty  out  1  high when FIFO empty and transmitter idle

Behaviour:
- One clock `clk`; reset `rst_n` is asynchronous, active-low. Reset values: txd=1, FIFO empty (count 0, pointers 0), ovf=0, divisor=DIV_RST, FSM=IDLE, shift reg 0, bit/clock counters 0. Outputs after reset: irq_empty=1, data_out=0.
- Writes are accepted on the rising edge when sel&we.
  - addr 0: push data_in[7:0] if not full. If full with no pop that cycle, drop the byte and set sticky ovf.
  - addr 1: any write clears ovf.
  - addr 2: divisor <= data_in[DIV_W-1:0].
  - addr 3: write ignored.
- Reads are combinational when sel&!we; otherwise data_out=0.
  - addr 0 reads 0.
  - addr 1 STATUS: bit0 busy (FSM!=IDLE), bit1 empty, bit2 full, bit3 ovf, bits[8+:FIFO_AW+1] count, other bits 0.
  - addr 2 reads the divisor, zero-extended.
  - addr 3 reads 0.
- FIFO:
  - count width FIFO_AW+1; pointers wrap modulo FIFO_DEPTH.
  - Simultaneous push and pop: push always accepted, count unchanged, including when full.
  - Pop when empty never occurs, because the FSM checks empty.
- Bit period P = divisor, with divisor 0 treated as 1. P is latched into an internal register at every frame load; divisor writes mid-frame affect only the next frame.
- FSM states IDLE, START, DATA, STOP:
  - IDLE: if !empty at an edge, pop the head into the shift reg, latch P, go to START. txd=0 from that edge.
  - START: txd=0 for P cycles, then DATA.
  - DATA: txd=shift[0] for P cycles per bit; shift right after each bit; 8 bits, then STOP.
  - STOP: txd=1 for P cycles.
  - At the final STOP edge: if !empty, pop and go directly to START (no idle gap); else go to IDLE.
- Frame length: exactly 10*P cycles. Push-to-start-bit latency from IDLE: txd falls on the edge after the write edge (1 cycle).
- irq_empty = empty & (FSM==IDLE), registered behaviour via state only (no extra delay).
- Reset mid-frame: txd returns high immediately (async); FIFO contents are lost.

Decomposition:
- Shared package/include: register offsets (CPRT_TXDATA=0, CPRT_STATUS=1, CPRT_DIV=2), STATUS bit positions, FSM state encodings, DIV_RST default.
- One natural sub-module: xcprt_fifo, a synchronous FIFO with push/pop/full/empty/count, parameterised by FIFO_DEPTH and width 8.

Test Plan:
1. Reset: hold rst_n=0 -> txd=1, irq_empty=1, STATUS read = 0x00000002, DIV read = 16.
2. Write DIV=4, then TXDATA=0x55 -> txd low 1 cycle after the write; bits 1,0,1,0,1,0,1,0 (LSB first) at 4 cycles each; stop high; busy for 40 cycles; then irq_empty=1.
3. Write DIV=2, push 0x41 and 0x42 back-to-back -> two 20-cycle frames, no idle gap between stop of 0x41 and start of 0x42.
4. DIV=100, push 9 bytes in consecutive cycles -> first popped immediately, 8 held; count=8, full=1, ovf=0. 10th push -> ovf=1 and the byte is dropped. Write STATUS -> ovf=0.
5. DIV=0 -> P=1, frame = 10 cycles. Write DIV=8 mid-frame -> current frame stays at P=1; next frame uses P=8.
6. Assert rst_n=0 mid-DATA -> txd=1 asynchronously; after release: count=0, FSM IDLE, no further transmission.
